// File: rtl/h14tx_timings_counter_pkg.sv
// Shared helpers for the h14tx timing counter: sync polarity mapping.
package h14tx_timings_counter_pkg;

   function automatic logic sync_level(input logic active, input logic active_high);
      return active_high ? active : ~active;
   endfunction

endpackage

// File: rtl/h14tx_timings_counter_if.sv
// Bundle of the timing counter's control inputs and raster outputs.
interface h14tx_timings_counter_if #(
   parameter int BitWidth  = 11,
   parameter int BitHeight = 10
);
   logic                 ce;
   logic                 restart;
   logic [BitWidth-1:0]  x;
   logic [BitHeight-1:0] y;
   logic                 hsync;
   logic                 vsync;
   logic                 de;
   logic                 line_start;
   logic                 frame_start;

   modport master (
      output ce, restart,
      input  x, y, hsync, vsync, de, line_start, frame_start
   );

   modport slave (
      input  ce, restart,
      output x, y, hsync, vsync, de, line_start, frame_start
   );
endinterface

// File: rtl/h14tx_wrap_counter.sv
// Modulo-Limit up-counter with clear; wrap flags the increment out of Limit-1.
module h14tx_wrap_counter #(
   parameter int Width = 11,
   parameter int Limit = 1650
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             clr,
   output logic [Width-1:0] value,
   output logic             wrap
);
   localparam logic [Width-1:0] Last = Width'(Limit - 1);

   logic [Width-1:0] value_q, value_d;

   assign wrap  = inc & (value_q == Last);
   assign value = value_q;

   always_comb begin
      value_d = value_q;
      if (clr || wrap) begin
         value_d = '0;
      end else if (inc) begin
         value_d = value_q + Width'(1);
      end
   end

   // Reset parks on the last position so the first increment lands on 0.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         value_q <= Last;
      end else begin
         value_q <= value_d;
      end
   end
endmodule

// File: rtl/h14tx_timings_counter.sv
// Raster position generator with registered sync, data-enable and start strobes.
module h14tx_timings_counter
   import h14tx_timings_counter_pkg::*;
#(
   parameter int BitWidth      = 11,
   parameter int BitHeight     = 10,
   parameter int FrameWidth    = 1650,
   parameter int FrameHeight   = 750,
   parameter int ActiveWidth   = 1280,
   parameter int ActiveHeight  = 720,
   parameter int HSyncStart    = 1390,
   parameter int HSyncWidth    = 40,
   parameter int VSyncStart    = 725,
   parameter int VSyncLines    = 5,
   parameter int HSyncPolarity = 1,
   parameter int VSyncPolarity = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ce,
   input  logic                 restart,
   output logic [BitWidth-1:0]  x,
   output logic [BitHeight-1:0] y,
   output logic                 hsync,
   output logic                 vsync,
   output logic                 de,
   output logic                 line_start,
   output logic                 frame_start
);
   localparam logic [BitWidth-1:0]  HsFirst = BitWidth'(HSyncStart);
   localparam logic [BitWidth-1:0]  HsLast  = BitWidth'(HSyncStart + HSyncWidth - 1);
   localparam logic [BitHeight-1:0] VsFirst = BitHeight'(VSyncStart);
   localparam logic [BitHeight-1:0] VsLast  = BitHeight'(VSyncStart + VSyncLines - 1);
   localparam logic [BitWidth-1:0]  ActW    = BitWidth'(ActiveWidth);
   localparam logic [BitHeight-1:0] ActH    = BitHeight'(ActiveHeight);
   localparam logic                 HsHigh  = (HSyncPolarity != 0);
   localparam logic                 VsHigh  = (VSyncPolarity != 0);

   if (ActiveWidth > HSyncStart) begin : g_bad_hact
      $error("ActiveWidth must not exceed HSyncStart");
   end
   if (HSyncStart + HSyncWidth > FrameWidth) begin : g_bad_hsync
      $error("hsync pulse runs past FrameWidth");
   end
   if (ActiveHeight > VSyncStart) begin : g_bad_vact
      $error("ActiveHeight must not exceed VSyncStart");
   end
   if (VSyncStart + VSyncLines > FrameHeight) begin : g_bad_vsync
      $error("vsync pulse runs past FrameHeight");
   end
   if (longint'(FrameWidth) > (longint'(1) << BitWidth)) begin : g_bad_bw
      $error("FrameWidth does not fit BitWidth");
   end
   if (longint'(FrameHeight) > (longint'(1) << BitHeight)) begin : g_bad_bh
      $error("FrameHeight does not fit BitHeight");
   end

   logic                 h_wrap, v_wrap, move;
   logic [BitWidth-1:0]  x_d;
   logic [BitHeight-1:0] y_d;
   logic hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
   logic line_start_q, line_start_d, frame_start_q, frame_start_d;

   h14tx_wrap_counter #(.Width(BitWidth), .Limit(FrameWidth)) u_hcnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (ce),
      .clr   (restart),
      .value (x),
      .wrap  (h_wrap)
   );

   h14tx_wrap_counter #(.Width(BitHeight), .Limit(FrameHeight)) u_vcnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (h_wrap),
      .clr   (restart),
      .value (y),
      .wrap  (v_wrap)
   );

   // Decode from the position the counters are about to load, so the
   // registered syncs line up with x/y in the same cycle.
   always_comb begin
      move = ce | restart;
      x_d  = x;
      y_d  = y;
      if (restart) begin
         x_d = '0;
         y_d = '0;
      end else if (ce) begin
         x_d = h_wrap ? '0 : x + BitWidth'(1);
         if (h_wrap) begin
            y_d = v_wrap ? '0 : y + BitHeight'(1);
         end
      end
      hsync_d       = move ? sync_level((x_d >= HsFirst) && (x_d <= HsLast), HsHigh) : hsync_q;
      vsync_d       = move ? sync_level((y_d >= VsFirst) && (y_d <= VsLast), VsHigh) : vsync_q;
      de_d          = move ? ((x_d < ActW) && (y_d < ActH)) : de_q;
      line_start_d  = restart | h_wrap;
      frame_start_d = restart | (h_wrap & v_wrap);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hsync_q       <= ~HsHigh;
         vsync_q       <= ~VsHigh;
         de_q          <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         de_q          <= de_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign de          = de_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;
endmodule

// File: tb/tb_h14tx_timings_counter.sv
// Randomized bench: two small-geometry counters checked against a linear pixel-index model.
module tb_h14tx_timings_counter;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   h14tx_timings_counter_if #(.BitWidth(5), .BitHeight(4)) if_a ();
   h14tx_timings_counter_if #(.BitWidth(4), .BitHeight(4)) if_b ();

   h14tx_timings_counter #(
      .BitWidth(5), .BitHeight(4), .FrameWidth(20), .FrameHeight(12),
      .ActiveWidth(12), .ActiveHeight(8), .HSyncStart(14), .HSyncWidth(3),
      .VSyncStart(9), .VSyncLines(2), .HSyncPolarity(1), .VSyncPolarity(1)
   ) dut_a (
      .clk(clk), .rst_n(rst_n), .ce(if_a.ce), .restart(if_a.restart),
      .x(if_a.x), .y(if_a.y), .hsync(if_a.hsync), .vsync(if_a.vsync), .de(if_a.de),
      .line_start(if_a.line_start), .frame_start(if_a.frame_start)
   );

   // Syncs end exactly at the frame edge and the frame fills BitWidth exactly.
   h14tx_timings_counter #(
      .BitWidth(4), .BitHeight(4), .FrameWidth(16), .FrameHeight(9),
      .ActiveWidth(10), .ActiveHeight(6), .HSyncStart(12), .HSyncWidth(4),
      .VSyncStart(7), .VSyncLines(2), .HSyncPolarity(0), .VSyncPolarity(0)
   ) dut_b (
      .clk(clk), .rst_n(rst_n), .ce(if_b.ce), .restart(if_b.restart),
      .x(if_b.x), .y(if_b.y), .hsync(if_b.hsync), .vsync(if_b.vsync), .de(if_b.de),
      .line_start(if_b.line_start), .frame_start(if_b.frame_start)
   );

   int fw[2]  = '{20, 16};
   int fh[2]  = '{12, 9};
   int aw[2]  = '{12, 10};
   int ah[2]  = '{8, 6};
   int hs0[2] = '{14, 12};
   int hsw[2] = '{3, 4};
   int vs0[2] = '{9, 7};
   int vsl[2] = '{2, 2};
   int pol[2] = '{1, 0};

   int   idx[2];
   logic m_hs[2], m_vs[2], m_de[2], m_ls[2], m_fs[2];

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s dut%0d: got %0d expected %0d at %0t", tag, d, obs, exp, $time);
      end
   endtask

   // Raster position is one linear index into the frame; x/y fall out by div/mod.
   task automatic model_step(input int d, input logic r_n, input logic c, input logic rs);
      int px, py;
      if (!r_n) begin
         idx[d]  = fw[d] * fh[d] - 1;
         m_hs[d] = (pol[d] == 0);
         m_vs[d] = (pol[d] == 0);
         m_de[d] = 1'b0;
         m_ls[d] = 1'b0;
         m_fs[d] = 1'b0;
      end else if (rs || c) begin
         idx[d]  = rs ? 0 : (idx[d] + 1) % (fw[d] * fh[d]);
         px      = idx[d] % fw[d];
         py      = idx[d] / fw[d];
         m_ls[d] = (px == 0);
         m_fs[d] = (idx[d] == 0);
         m_hs[d] = ((px >= hs0[d]) && (px < hs0[d] + hsw[d])) == (pol[d] != 0);
         m_vs[d] = ((py >= vs0[d]) && (py < vs0[d] + vsl[d])) == (pol[d] != 0);
         m_de[d] = (px < aw[d]) && (py < ah[d]);
      end else begin
         m_ls[d] = 1'b0;
         m_fs[d] = 1'b0;
      end
   endtask

   task automatic check_dut(input int d, input logic [31:0] ox, input logic [31:0] oy,
                            input logic ohs, input logic ovs, input logic ode,
                            input logic ols, input logic ofs);
      chk("x", d, ox, 32'(idx[d] % fw[d]));
      chk("y", d, oy, 32'(idx[d] / fw[d]));
      chk("hsync", d, 32'(ohs), 32'(m_hs[d]));
      chk("vsync", d, 32'(ovs), 32'(m_vs[d]));
      chk("de", d, 32'(ode), 32'(m_de[d]));
      chk("line_start", d, 32'(ols), 32'(m_ls[d]));
      chk("frame_start", d, 32'(ofs), 32'(m_fs[d]));
   endtask

   logic ce_v, rs_v;

   initial begin
      int r;
      int rs_hold;
      rs_hold    = 0;
      rst_n      = 1'b0;
      ce_v       = 1'b0;
      rs_v       = 1'b0;
      if_a.ce    = 1'b0; if_a.restart = 1'b0;
      if_b.ce    = 1'b0; if_b.restart = 1'b0;
      for (int cyc = 0; cyc < 5000; cyc++) begin
         @(posedge clk);
         for (int d = 0; d < 2; d++) model_step(d, rst_n, ce_v, rs_v);
         #1;
         check_dut(0, 32'(if_a.x), 32'(if_a.y), if_a.hsync, if_a.vsync, if_a.de,
                   if_a.line_start, if_a.frame_start);
         check_dut(1, 32'(if_b.x), 32'(if_b.y), if_b.hsync, if_b.vsync, if_b.de,
                   if_b.line_start, if_b.frame_start);

         // Directed opening: reset, hold after reset, a full line of ce,
         // restart held 3 cycles together with ce, then random traffic.
         if (cyc < 2) begin
            rst_n = 1'b0; ce_v = 1'b1; rs_v = 1'b1;
         end else if (cyc < 4) begin
            rst_n = 1'b1; ce_v = 1'b0; rs_v = 1'b0;
         end else if (cyc < 50) begin
            rst_n = 1'b1; ce_v = 1'b1; rs_v = 1'b0;
         end else if (cyc < 53) begin
            rst_n = 1'b1; ce_v = 1'b1; rs_v = 1'b1;
         end else begin
            r     = $urandom_range(0, 999);
            rst_n = (r >= 4);
            if (r >= 4 && r < 20) rs_hold = $urandom_range(1, 3);
            rs_v  = (rs_hold > 0);
            if (rs_hold > 0) rs_hold--;
            ce_v  = ($urandom_range(0, 3) != 0);
         end
         if_a.ce = ce_v; if_a.restart = rs_v;
         if_b.ce = ce_v; if_b.restart = rs_v;
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
